// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and opcode legality helper for the ALU round-robin arbiter.
// Optional opcode screening is enabled with `define ALU_OP_CHECK_EN.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 5'b01000;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 5'b00001;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 5'b11100;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 5'b11110;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 5'b00101;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 5'b01101;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 5'b00111;
    localparam logic [ALU_OP_W-1:0] OP_EQ   = 5'b11000;
    localparam logic [ALU_OP_W-1:0] OP_NE   = 5'b11001;
    localparam logic [ALU_OP_W-1:0] OP_GE   = 5'b11101;
    localparam logic [ALU_OP_W-1:0] OP_GEU  = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
            OP_SRA, OP_OR, OP_AND, OP_EQ, OP_NE, OP_GE, OP_GEU: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared ALU arbiter.
// rsp_err exists only when ALU_OP_CHECK_EN is defined.
interface alu_rr_arbiter_if #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 2
);
    import alu_pkg::*;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*N-1:0]        req_a;
    logic [NREQ*N-1:0]        req_b;
    logic [NREQ*ALU_OP_W-1:0] req_op;
    logic [NREQ-1:0]          rsp_valid;
    logic [NREQ-1:0]          rsp_ready;
    logic [N-1:0]             rsp_result;
    logic                     rsp_flag;
`ifdef ALU_OP_CHECK_EN
    logic                     rsp_err;
`endif

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flag
`ifdef ALU_OP_CHECK_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flag
`ifdef ALU_OP_CHECK_EN
        , output rsp_err
`endif
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic results for op[4]=0, compare flags for op[4]=1.
// SLT/SLTU drive both the 0/1 result and the flag so they also serve BLT/BLTU.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned LOGN = 5
) (
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [N-1:0]        result,
    output logic                flag
);

    logic [LOGN-1:0] shamt;
    logic            lt;
    logic            ltu;
    logic            eq;

    assign shamt = b[LOGN-1:0];
    assign lt    = $signed(a) < $signed(b);
    assign ltu   = a < b;
    assign eq    = a == b;

    always_comb begin
        result = '0;
        flag   = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = N'($signed(a) >>> shamt);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SLT:  begin result = N'(lt);  flag = lt;  end
            OP_SLTU: begin result = N'(ltu); flag = ltu; end
            OP_EQ:   flag = eq;
            OP_NE:   flag = !eq;
            OP_GE:   flag = !lt;
            OP_GEU:  flag = !ltu;
            default: begin result = '0; flag = 1'b0; end
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// One-hot round-robin select: first set valid bit at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && valid[PTR_W'(idx)]) begin
                grant[PTR_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ valid/ready requesters (IDLE -> EXEC -> RESP).
// Define ALU_OP_CHECK_EN to screen illegal opcodes and report them on rsp_err.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned LOGN = 5,
    parameter int unsigned NREQ = 2
) (
    input logic            clk,
    input logic            rst_n,
    alu_rr_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e                state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [NREQ-1:0]       grant;
    logic [N-1:0]          lat_a;
    logic [N-1:0]          lat_b;
    logic [ALU_OP_W-1:0]   lat_op;
    logic [NREQ-1:0]       rsp_valid_q;
    logic [N-1:0]          rsp_result_q;
    logic                  rsp_flag_q;

    logic [NREQ-1:0]       pick;
    logic [N-1:0]          sel_a;
    logic [N-1:0]          sel_b;
    logic [ALU_OP_W-1:0]   sel_op;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic [N-1:0]          alu_result;
    logic                  alu_flag;
    logic                  op_bad;
    logic                  rsp_fire;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick)
    );

    alu #(.N(N), .LOGN(LOGN)) u_alu (
        .a      (lat_a),
        .b      (lat_b),
        .op     (lat_op),
        .result (alu_result),
        .flag   (alu_flag)
    );

    // One-hot pick steers the winning requester's payload onto the latch inputs.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                sel_a  = sel_a  | bus.req_a[i*N +: N];
                sel_b  = sel_b  | bus.req_b[i*N +: N];
                sel_op = sel_op | bus.req_op[i*ALU_OP_W +: ALU_OP_W];
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
        next_ptr = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

`ifdef ALU_OP_CHECK_EN
    logic rsp_err_q;
    assign op_bad      = !is_legal_op(lat_op);
    assign bus.rsp_err = rsp_err_q;
`else
    assign op_bad = 1'b0;
`endif

    assign rsp_fire = |(bus.rsp_ready & grant);

    // Grant is offered only while idle and out of reset.
    assign bus.req_ready  = (rst_n && (state == ST_IDLE)) ? pick : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flag   = rsp_flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_op       <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
`ifdef ALU_OP_CHECK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        grant  <= pick;
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_op <= sel_op;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= op_bad ? '0 : alu_result;
                    rsp_flag_q   <= op_bad ? 1'b0 : alu_flag;
`ifdef ALU_OP_CHECK_EN
                    rsp_err_q    <= op_bad;
`endif
                    rsp_valid_q  <= grant;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        rr_ptr      <= next_ptr;
                        rsp_valid_q <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one alu datapath instance between NREQ requesters, for example the execute path and the branch-compare path of a multi-issue or multi-cycle variant of the core. Arbitration is round-robin. Each requester uses a valid/ready handshake. The arbiter latches the granted operands and opcode, drives the ALU for one cycle, and returns a registered Result and Flag to the granted requester. A response is held until that requester accepts it.

Parameters:
N, 32, operand/result width
LOGN, 5, shift-amount width; the ALU uses B[LOGN-1:0]
NREQ, 2, number of requesters (2..8)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot grant/accept, combinational
req_a  in  NREQ*N  operand A, requester i at slice [i*N +: N]
req_b  in  NREQ*N  operand B, same packing
req_op  in  NREQ*5  ALU opcode, slice [i*5 +: 5]
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  per-requester response accept
rsp_result  out  N  registered ALU Result
rsp_flag  out  1  registered ALU Flag

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (rst_n=0, any time including mid-operation):
  - state=IDLE, rr_ptr=0, grant register=0.
  - Latched operands and opcode=0. rsp_result=0, rsp_flag=0, rsp_valid=0. req_ready=0 combinationally.
  - Any in-flight operation is discarded without a response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr_ptr with wrap-around.
  - Assert req_ready for that bit only, in the same cycle.
  - Latch its a, b, op and the one-hot grant. Next state is EXEC.
  - If no req_valid is set, stay in IDLE.
- EXEC:
  - The ALU sees the latched a, b, op.
  - Register its Result into rsp_result and its Flag into rsp_flag. Next state is RESP.
- RESP:
  - rsp_valid equals the grant register.
  - rsp_result and rsp_flag stay stable until the handshake completes.
  - On rsp_ready[granted]=1: rr_ptr = (granted index + 1) mod NREQ. Next state is IDLE.
  - rsp_ready on non-granted bits is ignored.
- No new request is accepted in EXEC or RESP; req_ready=0 in those states.
- Latency: request accepted in cycle T; rsp_valid rises in cycle T+2. Minimum spacing between grants is 3 cycles.
- Requester rules: hold req_valid and operands stable until req_ready. Dropping req_valid before grant is allowed; that request is simply not served.
- Fairness: a continuously requesting requester is served at most NREQ-1 grants after any other requester.
- Arithmetic semantics are those of the ALU opcode map:
  - Result ops: ADD 00000, SUB 01000, SLL 00001, SLT 11100, SLTU 11110, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111.
  - Flag ops: EQ 11000, NE 11001, GE 11101, GEU 11111.
  - For ops with op[4]=1, the ALU forces Result=0 except SLT/SLTU.
  - For ops with op[4]=0, Flag=0.
  - The arbiter registers both outputs unconditionally.

Optional Feature:
ALU_OP_CHECK_EN
- Defined:
  - Adds output port rsp_err (1 bit, reset 0, valid with rsp_valid).
  - An opcode outside the 14 listed codes does not drive the ALU. rsp_result=0, rsp_flag=0, rsp_err=1.
  - Latency is unchanged.
- Undefined:
  - The port is absent and every opcode is passed to the ALU unchanged.

Decomposition:
- Package alu_pkg:
  - ALU opcode localparams (OP_ADD, OP_SUB, ... OP_GEU).
  - Opcode width constant ALU_OP_W=5.
  - FSM state enum typedef.
  - Function is_legal_op().
- Sub-module rr_pick (NREQ): combinational one-hot round-robin select from req_valid and rr_ptr.
- The alu datapath is instantiated once with N and LOGN passed through.

Test Plan:
1. Assert rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, rsp_result=0, rsp_flag=0.
2. req0 ADD a=5, b=7 accepted at T -> rsp_valid=2'b01 at T+2, rsp_result=12, rsp_flag=0.
3. Both valid after reset: req0 SUB 3,5 and req1 EQ 9,9 -> req0 granted first, result 0xFFFFFFFE. Then req1 granted, rsp_flag=1, rsp_result=0. rr_ptr ends at 0.
4. Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid and rsp_result stay stable; req_ready stays 0 despite pending req1.
5. req1 SRA a=0x80000000, b=36 -> shift of 4 -> rsp_result=0xF8000000. Then drop rst_n mid-EXEC on a following op -> no response, outputs 0.
6. With ALU_OP_CHECK_EN: op=5'b10000 -> rsp_err=1, rsp_result=0, rsp_flag=0. A following legal op gives rsp_err=0.
